tlc_bus_master: RTL and testbench
=================================

# tlc_bus_master

Bus initiator for the traffic light controller register interface: takes single register read/write commands from a host-side valid/ready port, runs one transfer on the `pvalid`/`pready` register bus, and returns read data and status on a response port. It sits between the system sequencer (or CPU bridge) and the controller's register file. It is the only driver of `paddr`, `pwdata`, `prd_wr` and `pvalid`.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum number of ACCESS cycles spent waiting for `pready` before abort. Legal range 1..65535.
- `pclk`  in  1  clock; all logic on the rising edge.
- `prst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_wr`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  8  byte address; must be word aligned.
- `cmd_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle response pulse; no backpressure.
- `rsp_rdata`  out  32  read data; 0 for writes and errors.
- `rsp_err`  out  1  1 = misaligned address or timeout.
- `paddr`  out  8  bus address.
- `pwdata`  out  32  bus write data.
- `prd_wr`  out  1  bus direction; 1 = write.
- `pvalid`  out  1  transfer request.
- `pready`  in  1  responder acknowledge.
- `prdata`  in  32  responder read data.

## Operation
- FSM states:
  - IDLE: `cmd_ready`=1. On `cmd_valid` with `cmd_ready` high at an edge, latch the command.
    - If `cmd_addr[1:0]` != 0: go to ERR; no bus cycle is issued.
    - Otherwise: drive `paddr`/`pwdata`/`prd_wr` from the command, set `pvalid`=1, go to ACCESS.
  - ACCESS: `paddr`, `pwdata`, `prd_wr` and `pvalid` are held stable.
    - Edge with `pready`=1: `pvalid`←0, `rsp_valid`←1, `rsp_err`←0, `rsp_rdata`←(read ? `prdata` : 0). Go to DONE.
  - ERR: `rsp_valid`←1, `rsp_err`←1, `rsp_rdata`←0. Go to DONE.
  - DONE: one cycle with `cmd_ready`=0, so the responder can drop `pready`. Then go to IDLE.
- `cmd_ready` is registered. It is 0 in every state except IDLE.
- The bus address/data registers keep their last value after a transfer; only `pvalid` returns to 0.
- `rsp_valid` is high for exactly one cycle per accepted command.

## Timing
- Reset values (applied asynchronously while `prst`=0):
  - outputs `cmd_ready`, `pvalid`, `prd_wr`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata`, `rsp_err` are all 0;
  - the FSM is in IDLE;
  - `cmd_ready` rises at the first rising edge after `prst` deasserts.
- The responder registers `pready` and `prdata` one edge after it samples `pvalid`=1.
- Normal transfer, command accepted at edge A:
  - `pvalid` is high after A;
  - `pready` is high after A+1;
  - the master samples it at A+2, so `rsp_valid` is high during the cycle after A+2.
- Minimum accept-to-response latency is 2 cycles.
- Back-to-back throughput is one command per 4 cycles.
- Misaligned command accepted at edge A: `rsp_valid`/`rsp_err` are high during the cycle after A+1.
- Reset mid-transfer: `pvalid` drops immediately and no response is produced. Any partially issued write is not retried.
- `pready`=1 seen outside ACCESS is ignored.

## Configuration
- `TLC_MASTER_TIMEOUT_EN` defined:
  - A 16-bit wait counter clears on entry to ACCESS and increments on each ACCESS edge with `pready`=0.
  - When it reaches `TIMEOUT_CYCLES`: `pvalid`←0, `rsp_valid`←1, `rsp_err`←1, `rsp_rdata`←0, go to DONE.
  - `pready` arriving on the same edge as the counter reaching the limit wins; the transfer completes normally.
- `TLC_MASTER_TIMEOUT_EN` undefined:
  - No counter; ACCESS waits indefinitely.
  - `rsp_err` is set only by misaligned addresses.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `tlc_pkg` holds:
  - register address constants: RED_TIME 8'h00, YELLOW_TIME 8'h04, GREEN_TIME 8'h08, MODE 8'h0C, STATUS 8'h10;
  - mode encodings: SWITCHOFF 0, BLINK 1, MANUAL 2, HIGH 3, LOW 4;
  - the master FSM state enum.
- One sub-module, `tlc_bus_timer`: loadable wait counter with terminal-count flag. It is instantiated only under `TLC_MASTER_TIMEOUT_EN`.

## Test plan
- Reset, then write 32'h0005_000A to 8'h00: bus shows `paddr`=8'h00, `prd_wr`=1, `pvalid` held until `pready`; `rsp_valid` pulses 2 cycles after accept with `rsp_err`=0 and `rsp_rdata`=0.
- Write 32'h3 to 8'h0C, then read 8'h0C: second response has `rsp_rdata`=32'h3; `cmd_ready` is low for 3 cycles after each accept.
- Command to address 8'h06: `pvalid` never rises; `rsp_valid`=1 and `rsp_err`=1 one cycle after accept.
- With the macro defined and `TIMEOUT_CYCLES`=4, responder holds `pready`=0: `pvalid` drops after 4 ACCESS cycles; `rsp_err`=1. Without the macro, `pvalid` stays high for 100 cycles.
- Assert `prst` during ACCESS: `pvalid` and `cmd_ready` go to 0 immediately; no `rsp_valid`; the next command after release completes normally.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller register interface:
// register map, mode encodings and the bus master FSM state type.
package tlc_pkg;

   localparam logic [7:0] RED_TIME    = 8'h00;
   localparam logic [7:0] YELLOW_TIME = 8'h04;
   localparam logic [7:0] GREEN_TIME  = 8'h08;
   localparam logic [7:0] MODE        = 8'h0C;
   localparam logic [7:0] STATUS      = 8'h10;

   localparam logic [2:0] SWITCHOFF = 3'd0;
   localparam logic [2:0] BLINK     = 3'd1;
   localparam logic [2:0] MANUAL    = 3'd2;
   localparam logic [2:0] HIGH      = 3'd3;
   localparam logic [2:0] LOW       = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_ERR,
      ST_DONE
   } master_state_t;

   function automatic logic is_word_aligned(input logic [7:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/tlc_bus_timer.sv
// Wait counter for the bus master: held at zero while clear is high, counts
// inc cycles, and flags the increment that would reach LIMIT.
module tlc_bus_timer
   import tlc_pkg::*;
#(
   parameter int unsigned LIMIT = 16
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic inc,
   output logic expire
);

   localparam logic [16:0] LIMIT_W = 17'(LIMIT);

   logic [15:0] count;

   // The flag looks one increment ahead so the FSM can abort on the very
   // edge where the count would hit the limit.
   assign expire = inc && (({1'b0, count} + 17'd1) == LIMIT_W);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/tlc_bus_master.sv
// Register bus initiator: one host command in, one pvalid/pready transfer out,
// one response pulse back. Wait timeout is built only with TLC_MASTER_TIMEOUT_EN.
module tlc_bus_master
   import tlc_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16
)
(
   input  logic        pclk,
   input  logic        prst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_wr,
   input  logic [7:0]  cmd_addr,
   input  logic [31:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [7:0]  paddr,
   output logic [31:0] pwdata,
   output logic        prd_wr,
   output logic        pvalid,
   input  logic        pready,
   input  logic [31:0] prdata
);

   master_state_t state;

   timeout_range : assert property (@(posedge pclk)
      (TIMEOUT_CYCLES >= 32'd1) && (TIMEOUT_CYCLES <= 32'd65535));

`ifdef TLC_MASTER_TIMEOUT_EN
   logic wait_expired;

   tlc_bus_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk    (pclk),
      .rst_n  (prst),
      .clear  (state != ST_ACCESS),
      .inc    ((state == ST_ACCESS) && !pready),
      .expire (wait_expired)
   );
`endif

   // DONE exists so the responder has a cycle to drop pready before the
   // next command can start; cmd_ready is raised on the way back to IDLE.
   always_ff @(posedge pclk or negedge prst) begin
      if (!prst) begin
         state     <= ST_IDLE;
         cmd_ready <= 1'b0;
         pvalid    <= 1'b0;
         prd_wr    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  if (!is_word_aligned(cmd_addr)) begin
                     state <= ST_ERR;
                  end else begin
                     paddr  <= cmd_addr;
                     pwdata <= cmd_wdata;
                     prd_wr <= cmd_wr;
                     pvalid <= 1'b1;
                     state  <= ST_ACCESS;
                  end
               end
            end
            ST_ACCESS: begin
               if (pready) begin
                  pvalid    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= prd_wr ? 32'd0 : prdata;
                  state     <= ST_DONE;
               end
`ifdef TLC_MASTER_TIMEOUT_EN
               else if (wait_expired) begin
                  pvalid    <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_rdata <= '0;
                  state     <= ST_DONE;
               end
`endif
            end
            ST_ERR: begin
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b1;
               rsp_rdata <= '0;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tlc_bus_master.sv
// Self-checking bench for tlc_bus_master with a registered responder and a
// word-array model of the register file; honours TLC_MASTER_TIMEOUT_EN.
module tb_tlc_bus_master;
   import tlc_pkg::*;

   localparam int TO = 4;

   typedef struct {
      bit          got;
      bit          err;
      logic [31:0] rdata;
      int          lat;
      int          low;
      bit          saw;
      logic [7:0]  addr;
      bit          wr;
      logic [31:0] wdata;
      bit          stable;
      bit          pulse;
      int          acc;
   } obs_t;

   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_wr = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err, prd_wr, pvalid;
   logic [31:0] rsp_rdata, pwdata;
   logic [7:0]  paddr;
   logic        pready;
   logic [31:0] prdata;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int stall_req = 0;
   bit hold = 1'b0;
   int wait_cnt;
   logic [31:0] resp_mem [64];
   logic [31:0] ref_mem [64];

   tlc_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
      .pclk(pclk), .prst(prst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pwdata(pwdata), .prd_wr(prd_wr), .pvalid(pvalid),
      .pready(pready), .prdata(prdata)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < 64; i++) resp_mem[i] <= 32'hA500_0000 | 32'(i);
   end

   // Responder: acknowledges one edge after seeing pvalid, after stall_req
   // extra wait cycles, or never while hold is set.
   always @(posedge pclk or negedge prst) begin
      if (!prst) begin
         pready   <= 1'b0;
         prdata   <= '0;
         wait_cnt <= 0;
      end else if (!pvalid) begin
         pready   <= 1'b0;
         wait_cnt <= 0;
      end else if (!pready) begin
         if (hold || wait_cnt < stall_req) begin
            wait_cnt <= wait_cnt + 1;
         end else begin
            pready <= 1'b1;
            if (prd_wr) resp_mem[paddr[7:2]] <= pwdata;
            else        prdata <= resp_mem[paddr[7:2]];
         end
      end
   end

   // Reference model: outcome of a command given the responder's stall count.
   task automatic predict(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input int stall, output bit e_err, output logic [31:0] e_rdata,
                          output int e_lat);
      if (addr[1:0] != 2'b00) begin
         e_err = 1'b1; e_rdata = '0; e_lat = 1;
      end
`ifdef TLC_MASTER_TIMEOUT_EN
      else if (stall + 1 >= TO) begin
         e_err = 1'b1; e_rdata = '0; e_lat = TO;
      end
`endif
      else begin
         e_err = 1'b0;
         e_lat = 2 + stall;
         e_rdata = wr ? 32'd0 : ref_mem[addr[7:2]];
         if (wr) ref_mem[addr[7:2]] = wdata;
      end
   endtask

   task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input int stall, output obs_t o);
      int n;
      o = '{default: 0};
      stall_req = stall;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 50) begin
         @(negedge pclk);
         n++;
      end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL cmd_ready_wait got %b exp 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wdata;
      @(posedge pclk);
      #1 o.acc = cyc;
      o.stable = 1'b1;
      for (int k = 1; k <= 300 && !o.got; k++) begin
         @(negedge pclk);
         cmd_valid = 1'b0;
         if (cmd_ready !== 1'b1) o.low++;
         if (pvalid === 1'b1) begin
            if (!o.saw) begin
               o.saw = 1'b1; o.addr = paddr; o.wr = prd_wr; o.wdata = pwdata;
            end else if (paddr !== o.addr || prd_wr !== o.wr || pwdata !== o.wdata) begin
               o.stable = 1'b0;
            end
         end
         if (rsp_valid === 1'b1) begin
            o.got = 1'b1; o.err = rsp_err; o.rdata = rsp_rdata; o.lat = k - 1;
         end
      end
      checks++;
      if (!o.got) begin
         errors++;
         $display("[TB] FAIL rsp_wait got no response exp response within 300 cycles");
      end else begin
         @(negedge pclk);
         o.pulse = (rsp_valid === 1'b0);
         if (cmd_ready !== 1'b1) o.low++;
      end
   endtask

   task automatic test_reset();
      prst = 1'b1;
      #1 prst = 1'b0;
      repeat (3) @(negedge pclk);
      checks++;
      if ({cmd_ready, pvalid, prd_wr, rsp_valid, rsp_err} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got %b exp 00000", {cmd_ready, pvalid, prd_wr, rsp_valid, rsp_err});
      end
      checks++;
      if ({paddr, pwdata, rsp_rdata} !== 72'd0) begin
         errors++;
         $display("[TB] FAIL reset_data got %h exp 0", {paddr, pwdata, rsp_rdata});
      end
      prst = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ready_before_edge got %b exp 0", cmd_ready);
      end
      @(posedge pclk);
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ready_after_edge got %b exp 1", cmd_ready);
      end
      @(negedge pclk);
   endtask

   task automatic test_write_basic();
      obs_t o;
      bit e_err; logic [31:0] e_rd; int e_lat;
      predict(1'b1, RED_TIME, 32'h0005_000A, 0, e_err, e_rd, e_lat);
      run_cmd(1'b1, RED_TIME, 32'h0005_000A, 0, o);
      checks++;
      if (o.err !== e_err || o.rdata !== e_rd) begin
         errors++;
         $display("[TB] FAIL wr_rsp got err=%b rd=%h exp err=%b rd=%h", o.err, o.rdata, e_err, e_rd);
      end
      checks++;
      if (o.lat !== 2) begin
         errors++;
         $display("[TB] FAIL wr_latency got %0d exp 2", o.lat);
      end
      checks++;
      if (o.addr !== 8'h00 || o.wr !== 1'b1 || o.wdata !== 32'h0005_000A || !o.stable) begin
         errors++;
         $display("[TB] FAIL wr_bus got a=%h w=%b d=%h st=%b exp a=00 w=1 d=0005000a st=1",
                  o.addr, o.wr, o.wdata, o.stable);
      end
      checks++;
      if (!o.pulse) begin
         errors++;
         $display("[TB] FAIL wr_pulse got rsp_valid held exp one cycle");
      end
   endtask

   task automatic test_write_read();
      obs_t ow, orr;
      bit e_err; logic [31:0] e_rd; int e_lat;
      predict(1'b1, MODE, 32'(HIGH), 0, e_err, e_rd, e_lat);
      run_cmd(1'b1, MODE, 32'(HIGH), 0, ow);
      predict(1'b0, MODE, 32'd0, 0, e_err, e_rd, e_lat);
      run_cmd(1'b0, MODE, 32'd0, 0, orr);
      checks++;
      if (orr.rdata !== 32'h3 || orr.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_mode got err=%b rd=%h exp err=0 rd=00000003", orr.err, orr.rdata);
      end
      checks++;
      if (ow.low !== 3 || orr.low !== 3) begin
         errors++;
         $display("[TB] FAIL ready_low got %0d/%0d exp 3/3", ow.low, orr.low);
      end
      checks++;
      if (orr.acc - ow.acc !== 4) begin
         errors++;
         $display("[TB] FAIL accept_spacing got %0d exp 4", orr.acc - ow.acc);
      end
      checks++;
      if (orr.addr !== MODE || orr.wr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rd_bus got a=%h w=%b exp a=0c w=0", orr.addr, orr.wr);
      end
   endtask

   task automatic test_misaligned();
      obs_t o;
      run_cmd(1'b1, 8'h06, 32'hFFFF_FFFF, 0, o);
      checks++;
      if (o.saw !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mis_pvalid got pvalid raised exp never");
      end
      checks++;
      if (o.err !== 1'b1 || o.rdata !== 32'd0 || o.lat !== 1) begin
         errors++;
         $display("[TB] FAIL mis_rsp got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=1", o.err, o.rdata, o.lat);
      end
      checks++;
      if (!o.pulse || o.low !== 2) begin
         errors++;
         $display("[TB] FAIL mis_timing got pulse=%b low=%0d exp pulse=1 low=2", o.pulse, o.low);
      end
   endtask

   task automatic test_stall_boundary();
      obs_t o;
      bit e_err; logic [31:0] e_rd; int e_lat;
      predict(1'b0, STATUS, 32'd0, 2, e_err, e_rd, e_lat);
      run_cmd(1'b0, STATUS, 32'd0, 2, o);
      checks++;
      if (o.err !== e_err || o.rdata !== e_rd || o.lat !== e_lat) begin
         errors++;
         $display("[TB] FAIL stall2 got err=%b rd=%h lat=%0d exp err=%b rd=%h lat=%0d",
                  o.err, o.rdata, o.lat, e_err, e_rd, e_lat);
      end
      predict(1'b0, GREEN_TIME, 32'd0, 3, e_err, e_rd, e_lat);
      run_cmd(1'b0, GREEN_TIME, 32'd0, 3, o);
      checks++;
      if (o.err !== e_err || o.rdata !== e_rd || o.lat !== e_lat) begin
         errors++;
         $display("[TB] FAIL stall3 got err=%b rd=%h lat=%0d exp err=%b rd=%h lat=%0d",
                  o.err, o.rdata, o.lat, e_err, e_rd, e_lat);
      end
      predict(1'b1, YELLOW_TIME, 32'h0000_0007, 0, e_err, e_rd, e_lat);
      run_cmd(1'b1, YELLOW_TIME, 32'h0000_0007, 0, o);
      checks++;
      if (o.err !== e_err || o.lat !== e_lat) begin
         errors++;
         $display("[TB] FAIL after_stall got err=%b lat=%0d exp err=%b lat=%0d", o.err, o.lat, e_err, e_lat);
      end
   endtask

   task automatic test_timeout_hold();
      obs_t o;
      bit e_err; logic [31:0] e_rd; int e_lat;
`ifdef TLC_MASTER_TIMEOUT_EN
      hold = 1'b1;
      run_cmd(1'b1, GREEN_TIME, 32'h0000_1234, 0, o);
      hold = 1'b0;
      checks++;
      if (o.err !== 1'b1 || o.rdata !== 32'd0 || o.lat !== TO || !o.saw) begin
         errors++;
         $display("[TB] FAIL timeout got err=%b rd=%h lat=%0d saw=%b exp err=1 rd=0 lat=%0d saw=1",
                  o.err, o.rdata, o.lat, o.saw, TO);
      end
`else
      int hi;
      bit seen;
      bit got;
      hold = 1'b1;
      stall_req = 0;
      for (int n = 0; n < 50 && cmd_ready !== 1'b1; n++) @(negedge pclk);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = GREEN_TIME; cmd_wdata = 32'h0000_1234;
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0;
      hi = 0; seen = 1'b0;
      repeat (100) begin
         if (pvalid === 1'b1) hi++;
         if (rsp_valid === 1'b1) seen = 1'b1;
         @(negedge pclk);
      end
      checks++;
      if (hi !== 100 || seen) begin
         errors++;
         $display("[TB] FAIL hold_wait got hi=%0d rsp=%b exp hi=100 rsp=0", hi, seen);
      end
      hold = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge pclk);
         if (rsp_valid === 1'b1) begin
            got = 1'b1;
            o.err = rsp_err;
         end
      end
      checks++;
      if (!got || o.err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_release got rsp=%b err=%b exp rsp=1 err=0", got, o.err);
      end
      ref_mem[GREEN_TIME[7:2]] = 32'h0000_1234;
      @(negedge pclk);
`endif
      predict(1'b0, GREEN_TIME, 32'd0, 0, e_err, e_rd, e_lat);
      run_cmd(1'b0, GREEN_TIME, 32'd0, 0, o);
      checks++;
      if (o.err !== e_err || o.rdata !== e_rd) begin
         errors++;
         $display("[TB] FAIL hold_readback got err=%b rd=%h exp err=%b rd=%h", o.err, o.rdata, e_err, e_rd);
      end
   endtask

   task automatic test_reset_mid();
      obs_t o;
      bit seen;
      bit e_err; logic [31:0] e_rd; int e_lat;
      hold = 1'b1;
      for (int n = 0; n < 50 && cmd_ready !== 1'b1; n++) @(negedge pclk);
      cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = YELLOW_TIME; cmd_wdata = 32'hDEAD_BEEF;
      @(posedge pclk);
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      checks++;
      if (pvalid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_access got pvalid=%b exp 1", pvalid);
      end
      #2 prst = 1'b0;
      #1;
      checks++;
      if (pvalid !== 1'b0 || cmd_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_reset got pvalid=%b ready=%b exp 0/0", pvalid, cmd_ready);
      end
      seen = 1'b0;
      repeat (4) begin
         @(negedge pclk);
         if (rsp_valid === 1'b1) seen = 1'b1;
      end
      hold = 1'b0;
      prst = 1'b1;
      checks++;
      if (seen) begin
         errors++;
         $display("[TB] FAIL mid_no_rsp got rsp_valid=1 exp 0");
      end
      predict(1'b0, YELLOW_TIME, 32'd0, 0, e_err, e_rd, e_lat);
      run_cmd(1'b0, YELLOW_TIME, 32'd0, 0, o);
      checks++;
      if (o.err !== e_err || o.rdata !== e_rd || o.lat !== e_lat) begin
         errors++;
         $display("[TB] FAIL post_reset got err=%b rd=%h lat=%0d exp err=%b rd=%h lat=%0d",
                  o.err, o.rdata, o.lat, e_err, e_rd, e_lat);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      int prev;
      logic [7:0] a;
      bit e_err; logic [31:0] e_rd; int e_lat;
      prev = -1;
      for (int i = 0; i < 5; i++) begin
         a = {$urandom_range(0, 63), 2'b00};
         predict(1'b0, a, 32'd0, 0, e_err, e_rd, e_lat);
         run_cmd(1'b0, a, 32'd0, 0, o);
         checks++;
         if (o.rdata !== e_rd || o.err !== e_err) begin
            errors++;
            $display("[TB] FAIL b2b_rd[%0d] got %h exp %h", i, o.rdata, e_rd);
         end
         if (prev >= 0) begin
            checks++;
            if (o.acc - prev !== 4) begin
               errors++;
               $display("[TB] FAIL b2b_spacing[%0d] got %0d exp 4", i, o.acc - prev);
            end
         end
         prev = o.acc;
      end
   endtask

   task automatic test_random();
      obs_t o;
      bit wr;
      logic [7:0] a;
      logic [31:0] d;
      int s;
      bit e_err; logic [31:0] e_rd; int e_lat;
      for (int i = 0; i < 40; i++) begin
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) a = {6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
         else                           a = {6'($urandom_range(0, 63)), 2'b00};
         d = $urandom;
         s = $urandom_range(0, 2);
         predict(wr, a, d, s, e_err, e_rd, e_lat);
         run_cmd(wr, a, d, s, o);
         checks++;
         if (o.err !== e_err || o.rdata !== e_rd || o.lat !== e_lat || !o.pulse) begin
            errors++;
            $display("[TB] FAIL rand[%0d] got err=%b rd=%h lat=%0d pulse=%b exp err=%b rd=%h lat=%0d pulse=1",
                     i, o.err, o.rdata, o.lat, o.pulse, e_err, e_rd, e_lat);
         end
         if (a[1:0] == 2'b00) begin
            checks++;
            if (o.addr !== a || o.wr !== wr || !o.stable) begin
               errors++;
               $display("[TB] FAIL rand_bus[%0d] got a=%h w=%b st=%b exp a=%h w=%b st=1",
                        i, o.addr, o.wr, o.stable, a, wr);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
      test_reset();
      test_write_basic();
      test_write_read();
      test_misaligned();
      test_stall_boundary();
      test_timeout_hold();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
